// File: rtl/bf2_bundle_pipe_if.sv
`default_nettype none
// ============================================================================
// bf2_bundle_pipe_if : valid/ready bundle bus for the radix-2 butterfly pipe
//                      (rot_j present only when BF2_ROT_J_EN is defined)
// Rev 1.0
// ============================================================================
interface bf2_bundle_pipe_if #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_last;
  logic                    scale;
  logic signed [WIDTH-1:0] din_R  [DEPTH];
  logic signed [WIDTH-1:0] din_Q  [DEPTH];
`ifdef BF2_ROT_J_EN
  logic                    rot_j;
`endif
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_last;
  logic signed [WIDTH:0]   dout_R [DEPTH];
  logic signed [WIDTH:0]   dout_Q [DEPTH];

  modport master (
`ifdef BF2_ROT_J_EN
    output rot_j,
`endif
    output in_valid, in_last, scale, din_R, din_Q, out_ready,
    input  in_ready, out_valid, out_last, dout_R, dout_Q
  );

  modport slave (
`ifdef BF2_ROT_J_EN
    input  rot_j,
`endif
    input  in_valid, in_last, scale, din_R, din_Q, out_ready,
    output in_ready, out_valid, out_last, dout_R, dout_Q
  );
endinterface
`default_nettype wire

// File: rtl/bf2_bundle_pipe.sv
`default_nettype none
// ============================================================================
// bf2_bundle_pipe : 2-stage valid/ready radix-2 butterfly over a DEPTH-lane
//                   bundle; optional -j rotation of lane c via BF2_ROT_J_EN
// Rev 1.0
// ============================================================================
module bf2_bundle_pipe #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 16,
  parameter int OFFSET = 4
) (
  input  logic             clk,
  input  logic             rst,
  bf2_bundle_pipe_if.slave bus
);

  localparam int NBLK = DEPTH / (2 * OFFSET);

  generate
    if (DEPTH % (2 * OFFSET) != 0) begin : g_bad_cfg
      $error("bf2_bundle_pipe: DEPTH must be a multiple of 2*OFFSET");
    end
  endgenerate

  function automatic logic signed [WIDTH+1:0] sx(input logic signed [WIDTH-1:0] v);
    return (WIDTH+2)'(v);
  endfunction

  // Round-half-up halving; the WIDTH+2 intermediate keeps s+1 from wrapping.
  function automatic logic signed [WIDTH:0] scl(input logic signed [WIDTH+1:0] s,
                                                 input logic half);
    logic signed [WIDTH+1:0] t;
    t = (s + (WIDTH+2)'(1)) >>> 1;
    return half ? (WIDTH+1)'(t) : (WIDTH+1)'(s);
  endfunction

  logic adv;
  logic out_valid_q;

  logic                    s1_v_q;
  logic                    s1_scale_q;
  logic                    s1_last_q;
  logic signed [WIDTH-1:0] s1_r_q [DEPTH];
  logic signed [WIDTH-1:0] s1_i_q [DEPTH];
`ifdef BF2_ROT_J_EN
  logic                    s1_rot_q;
`endif

  logic                    out_last_q;
  logic signed [WIDTH:0]   dout_r_q [DEPTH];
  logic signed [WIDTH:0]   dout_i_q [DEPTH];
  logic signed [WIDTH:0]   dout_r_d [DEPTH];
  logic signed [WIDTH:0]   dout_i_d [DEPTH];

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q     <= 1'b0;
      s1_scale_q <= 1'b0;
      s1_last_q  <= 1'b0;
`ifdef BF2_ROT_J_EN
      s1_rot_q   <= 1'b0;
`endif
      for (int k = 0; k < DEPTH; k++) begin
        s1_r_q[k] <= '0;
        s1_i_q[k] <= '0;
      end
    end else if (adv) begin
      s1_v_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_scale_q <= bus.scale;
        s1_last_q  <= bus.in_last;
`ifdef BF2_ROT_J_EN
        s1_rot_q   <= bus.rot_j;
`endif
        for (int k = 0; k < DEPTH; k++) begin
          s1_r_q[k] <= bus.din_R[k];
          s1_i_q[k] <= bus.din_Q[k];
        end
      end
    end
  end

  always_comb begin
    logic signed [WIDTH+1:0] ar, ai, cr, ci;
    int a, c;
    ar = '0;
    ai = '0;
    cr = '0;
    ci = '0;
    a  = 0;
    c  = 0;
    for (int k = 0; k < DEPTH; k++) begin
      dout_r_d[k] = '0;
      dout_i_d[k] = '0;
    end
    for (int b = 0; b < NBLK; b++) begin
      for (int i = 0; i < OFFSET; i++) begin
        a  = b * 2 * OFFSET + i;
        c  = a + OFFSET;
        ar = sx(s1_r_q[a]);
        ai = sx(s1_i_q[a]);
        cr = sx(s1_r_q[c]);
        ci = sx(s1_i_q[c]);
`ifdef BF2_ROT_J_EN
        // -j rotation: (R,Q) -> (Q,-R); negation is done after widening.
        if (s1_rot_q) begin
          cr = sx(s1_i_q[c]);
          ci = -sx(s1_r_q[c]);
        end
`endif
        dout_r_d[a] = scl(ar + cr, s1_scale_q);
        dout_i_d[a] = scl(ai + ci, s1_scale_q);
        dout_r_d[c] = scl(ar - cr, s1_scale_q);
        dout_i_d[c] = scl(ai - ci, s1_scale_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        dout_r_q[k] <= '0;
        dout_i_q[k] <= '0;
      end
    end else if (adv) begin
      out_valid_q <= s1_v_q;
      if (s1_v_q) begin
        out_last_q <= s1_last_q;
        for (int k = 0; k < DEPTH; k++) begin
          dout_r_q[k] <= dout_r_d[k];
          dout_i_q[k] <= dout_i_d[k];
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_last  = out_last_q;
  assign bus.dout_R    = dout_r_q;
  assign bus.dout_Q    = dout_i_q;

endmodule
`default_nettype wire
